// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: single mid-bit sample per bit, one-cycle done/ferr strobes.
// A stop bit sampled low parks the receiver in WAIT_HIGH until the line returns high.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_done,
    output logic       uart_rx_busy,
    output logic       uart_rx_ferr
);
    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_HALF    = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state, state_nxt;
    logic                rxd_s1, rxd_s2, rxd_s3;
    logic [CNT_W-1:0]    baud_cnt, baud_cnt_nxt;
    logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0]   shift_reg, shift_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                done_nxt, busy_nxt, ferr_nxt;
    logic                fall_c, sample_c, wrap_c;

    // Three-flop synchronizer; s3 only exists to detect the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    assign fall_c   = rxd_s3 & ~rxd_s2;
    assign sample_c = (baud_cnt == CNT_W'(BAUD_HALF));
    assign wrap_c   = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            uart_rx_data <= '0;
            uart_rx_done <= 1'b0;
            uart_rx_busy <= 1'b0;
            uart_rx_ferr <= 1'b0;
        end else begin
            state        <= state_nxt;
            baud_cnt     <= baud_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift_reg    <= shift_nxt;
            uart_rx_data <= data_nxt;
            uart_rx_done <= done_nxt;
            uart_rx_busy <= busy_nxt;
            uart_rx_ferr <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        data_nxt     = uart_rx_data;
        done_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        busy_nxt     = uart_rx_busy;

        // Bit timer is free-running only while a frame is in flight.
        if (state == START || state == DATA || state == STOP) begin
            baud_cnt_nxt = wrap_c ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (fall_c) begin
                    baud_cnt_nxt = '0;
                    busy_nxt     = 1'b1;
                    state_nxt    = START;
                end
            end
            START: begin
                if (sample_c && rxd_s2) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (wrap_c) begin
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_nxt[bit_idx] = rxd_s2;
                end
                if (wrap_c) begin
                    if (bit_idx == IDX_W'(7)) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so an immediately following start bit is caught.
                if (sample_c) begin
                    if (rxd_s2) begin
                        data_nxt  = shift_reg;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_s2) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT_CLKS = 217;
    localparam int FAST_CLKS = 213;
    localparam int SLOW_CLKS = 221;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_rx_busy;
    logic       uart_rx_ferr;

    exp_t            exp_q[$];
    longint unsigned done_cyc[$];
    longint unsigned cyc = 0;
    logic [7:0]      model_data = 8'h00;
    int              checks = 0;
    int              failures = 0;
    logic [7:0]      sweep [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E, 8'hA5, 8'h3C, 8'hC3,
                                    8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hED};

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .uart_rx_data(uart_rx_data),
        .uart_rx_done(uart_rx_done),
        .uart_rx_busy(uart_rx_busy),
        .uart_rx_ferr(uart_rx_ferr)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame starting at a negedge; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_val);
        uart_rxd = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b, input int bit_clks);
        exp_q.push_back('{is_ferr: 1'b0, data: b});
        send_byte(b, bit_clks, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, 32'(uart_rx_data), 32'h00);
        check({tag, "_done"}, 32'(uart_rx_done), 32'd0);
        check({tag, "_busy"}, 32'(uart_rx_busy), 32'd0);
        check({tag, "_ferr"}, 32'(uart_rx_ferr), 32'd0);
    endtask

    // Monitor: every done/ferr strobe must match the head of the expectation queue.
    initial begin
        exp_t e;
        logic prev_done = 1'b0;
        logic prev_ferr = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_data = 8'h00;
                prev_done  = 1'b0;
                prev_ferr  = 1'b0;
            end else begin
                if (uart_rx_done || uart_rx_ferr) begin
                    check("strobe_exclusive", 32'(uart_rx_done & uart_rx_ferr), 32'd0);
                    check("strobe_width", 32'((uart_rx_done & prev_done) | (uart_rx_ferr & prev_ferr)), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", {uart_rx_done, uart_rx_ferr, 22'd0, uart_rx_data}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", 32'(uart_rx_ferr), 32'(e.is_ferr));
                        if (e.is_ferr) begin
                            check("ferr_data_hold", 32'(uart_rx_data), 32'(model_data));
                        end else begin
                            check("rx_data", 32'(uart_rx_data), 32'(e.data));
                            check("busy_after_done", 32'(uart_rx_busy), 32'd0);
                            model_data = e.data;
                        end
                    end
                    if (uart_rx_done) done_cyc.push_back(cyc);
                end
                prev_done = uart_rx_done;
                prev_ferr = uart_rx_ferr;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        repeat (5) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte
        send_good(8'h55, BIT_CLKS);
        wait_drain("drain_55");

        // Back-to-back frames with a one-bit stop: done pulses one frame apart
        n0 = done_cyc.size();
        send_good(8'hA3, BIT_CLKS);
        send_good(8'h5C, BIT_CLKS);
        wait_drain("drain_b2b");
        if (done_cyc.size() >= n0 + 2)
            check("b2b_spacing", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd2170);
        else
            check("b2b_count", 32'(done_cyc.size() - n0), 32'd2);

        // Short low glitch in idle is rejected at the start-bit sample
        uart_rxd = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_busy", 32'(uart_rx_busy), 32'd1);
        repeat (20) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_busy_low", 32'(uart_rx_busy), 32'd0);
        check("glitch_data_hold", 32'(uart_rx_data), 32'h5C);

        // Framing error, line held low (break), then recovery
        exp_q.push_back('{is_ferr: 1'b1, data: 8'h00});
        send_byte(8'hF0, BIT_CLKS, 1'b0);
        repeat (10 * BIT_CLKS) @(negedge clk);
        check("break_busy", 32'(uart_rx_busy), 32'd1);
        check("break_data_hold", 32'(uart_rx_data), 32'h5C);
        repeat (10 * BIT_CLKS) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("break_release_busy", 32'(uart_rx_busy), 32'd0);
        wait_drain("drain_ferr");
        repeat (BIT_CLKS) @(negedge clk);
        send_good(8'h0F, BIT_CLKS);
        wait_drain("drain_0f");

        // Reset during data bit 4 discards the partial frame
        fork
            send_byte(8'hBE, BIT_CLKS, 1'b1);
            begin
                repeat (5 * BIT_CLKS + 100) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_vals("midframe_rst");
            end
        join
        repeat (10) @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_good(8'h81, BIT_CLKS);
        wait_drain("drain_81");

        // Byte sweep at nominal, +2% and -2% sender bit period
        for (int i = 0; i < 16; i++) begin
            send_good(sweep[i], (i < 8) ? BIT_CLKS : ((i < 12) ? FAST_CLKS : SLOW_CLKS));
        end
        wait_drain("drain_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
